raster_frame_capture: RTL
=========================

# raster_frame_capture

Receives the serial 56×56 canvas raster stream (one value bit per sample plus x/y coordinates, advanced on a 6.25 MHz clock) and rebuilds it as a pooled 28×28 bitmap in the clk_100M domain. It is the receiving end of the canvas-to-classifier raster interface. It double-buffers completed frames and exposes the published frame through a random-access read port with a valid/ack handshake, so the recognizer or a display path can consume whole frames.

## Interface
- SRC_DIM, 56: source raster side length; the last sample of a frame is (SRC_DIM-1, SRC_DIM-1).
- POOL, 2: pooling factor per axis. SRC_DIM must be divisible by POOL.
- DST_DIM, SRC_DIM/POOL: side length of the stored bitmap. Derived; do not override.
- clk_100M  in  1  system clock; all state is in this domain.
- reset  in  1  asynchronous, active-high.
- pix_clk  in  1  6.25 MHz raster clock, treated as a level; the producer updates its outputs on its rising edge.
- pix_val  in  1  sample value.
- pix_x  in  10  sample column.
- pix_y  in  10  sample row.
- frame_valid  out  1  high while the read bank holds an unconsumed frame.
- frame_ack  in  1  consumer release; sampled only while frame_valid=1.
- rd_addr  in  10  cell index, equal to row*DST_DIM + col.
- rd_data  out  CELL_W  registered cell value. CELL_W=1, or 3 with the count option enabled.
- frame_count  out  8  number of published frames; wraps at 255→0.
- overrun  out  1  sticky; a completed frame was dropped.

## Operation
- pix_clk passes through a 2-flop synchronizer and a falling-edge detector. The detector output is the one-cycle strobe `stb`. Sampling on the falling edge lands mid-window (8 cycles of stability). pix_val, pix_x and pix_y are captured without synchronizers on `stb`.
- Samples with pix_x ≥ SRC_DIM or pix_y ≥ SRC_DIM are ignored.
- FSM states:
  - UNSYNC (reset state): samples are discarded. Go to CAPTURE on a sample at (0,0), and write that sample.
  - CAPTURE: every in-range sample is written. A sample at (0,0) mid-frame restarts the frame; the FSM stays in CAPTURE.
- Cell index = (pix_y/POOL)*DST_DIM + pix_x/POOL.
- No bank clearing is performed:
  - For the aligned sample (pix_x%POOL==0 and pix_y%POOL==0), the cell is set to pix_val.
  - For any other sample, the cell is set to old|pix_val.
  - This is correct for row-major and column-major scan alike.
- Two banks are used: write bank W (reset 0) and read bank R (reset 1).
- Frame end occurs when the sample at (SRC_DIM-1, SRC_DIM-1) completes its write:
  - If frame_valid=0: swap W and R, set frame_valid=1, and increment frame_count.
  - If frame_valid=1: do not swap, set overrun=1, and let the next frame overwrite W. The published frame is untouched.
- frame_ack=1 while frame_valid=1 clears frame_valid on the next cycle. frame_ack while frame_valid=0 is ignored.
- Simultaneous ack and frame end in the same cycle: the ack is applied first, then the swap. frame_valid stays 1, frame_count increments, and overrun is unchanged.
- Reads:
  - rd_data = R[rd_addr], registered.
  - rd_addr ≥ DST_DIM² returns 0.
  - A swap changes rd_data starting from the cycle after frame_valid rises.

## Timing
- `stb` asserts 3 clk_100M cycles after the pix_clk falling edge.
- Write pipeline:
  - stb cycle: capture the sample.
  - +1: compute the index and read the old cell.
  - +2: write the cell.
  - +3: frame-end evaluation, swap and frame_valid.
  - Worst case, frame_valid rises 6 cycles after the final pix_clk falling edge.
- Samples arrive 16 cycles apart, so there is no RMW hazard. A second `stb` arriving within 4 cycles is not required to be handled.
- rd_data latency is 1 cycle.
- Reset values: frame_valid=0, rd_data=0, frame_count=0, overrun=0, FSM=UNSYNC, W=0, R=1. Bitmap contents are not reset.
- Reset mid-frame discards the partial frame. Publishing requires a new (0,0) sample.

## Configuration
- RASTER_CAPTURE_COUNT_EN defined:
  - CELL_W=3 and each cell holds the number of set samples, 0..POOL².
  - The aligned sample writes {2'b0,pix_val}; other samples write old+pix_val.
  - Full coverage reads 4.
- Undefined: CELL_W=1 and each cell holds the OR of its POOL×POOL samples.

## Test plan
- Reset, then one full frame with only (x=10, y=20)=1 -> after the last sample, frame_valid=1 and frame_count=1; rd_addr 285 reads 1; all other addresses read 0; rd_addr 800 reads 0.
- All-ones frame -> addresses 0..783 read 1 (4 with COUNT_EN).
- Two full frames with no ack (frame 1 pixel (0,0)=1, frame 2 all zero) -> overrun=1, frame_count=1, addr 0 still reads 1. After ack, the third frame publishes and frame_count=2.
- Assert frame_ack exactly in the frame-end evaluation cycle of frame 2 -> frame_valid stays 1, frame_count=2, overrun=0, and the read bank now shows frame 2.
- Stream begins at (30,0) after reset -> no frame_valid at the first (55,55). The next frame starting at (0,0) publishes with frame_count=1.
- Assert reset during row 20 of a capture -> all outputs return to reset values and FSM=UNSYNC. The frame resumed mid-stream is not published.

Source files
------------

// File: rtl/raster_frame_capture.sv
// Rebuilds the serial SRC_DIM x SRC_DIM canvas raster as a pooled DST_DIM x DST_DIM
// double-buffered bitmap. Define RASTER_CAPTURE_COUNT_EN for per-cell set-sample counts.
module raster_frame_capture #(
    parameter int SRC_DIM = 56,
    parameter int POOL = 2,
    localparam int DST_DIM = SRC_DIM / POOL,
`ifdef RASTER_CAPTURE_COUNT_EN
    localparam int CELL_W = 3
`else
    localparam int CELL_W = 1
`endif
) (
    input  logic              clk_100M,
    input  logic              reset,
    input  logic              pix_clk,
    input  logic              pix_val,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic              frame_valid,
    input  logic              frame_ack,
    input  logic [9:0]        rd_addr,
    output logic [CELL_W-1:0] rd_data,
    output logic [7:0]        frame_count,
    output logic              overrun,
    output logic              fsm_state
);

    localparam int NCELL = DST_DIM * DST_DIM;
    localparam logic [9:0] SRC_LIM  = 10'(SRC_DIM);
    localparam logic [9:0] SRC_LAST = 10'(SRC_DIM - 1);
    localparam logic [9:0] POOL_W   = 10'(POOL);
    localparam logic [9:0] DST_W    = 10'(DST_DIM);
    localparam logic [9:0] NCELL_W  = 10'(NCELL);

    typedef enum logic {UNSYNC = 1'b0, CAPTURE = 1'b1} state_t;

    state_t state, state_next;

    logic              pix_s1, pix_s2, pix_s3;
    logic              stb;
    logic              cap_vld, cap_val;
    logic [9:0]        cap_x, cap_y;
    logic              in_range, is_origin, is_last, aligned, accept;
    logic [9:0]        cell_idx;
    logic              b_vld, b_val, b_aligned, b_last;
    logic [9:0]        b_idx;
    logic [CELL_W-1:0] b_old, val_ext, new_cell;
    logic              c_last;
    logic              w_bank, r_bank, fv_held;

    logic [CELL_W-1:0] bank_mem [2][NCELL];

    // pix_clk is a level from a slow domain; sample on its falling edge, mid data window.
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            pix_s1 <= 1'b0;
            pix_s2 <= 1'b0;
            pix_s3 <= 1'b0;
        end else begin
            pix_s1 <= pix_clk;
            pix_s2 <= pix_s1;
            pix_s3 <= pix_s2;
        end
    end

    assign stb = pix_s3 & ~pix_s2;

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            cap_vld <= 1'b0;
            cap_val <= 1'b0;
            cap_x   <= '0;
            cap_y   <= '0;
        end else begin
            cap_vld <= stb;
            if (stb) begin
                cap_val <= pix_val;
                cap_x   <= pix_x;
                cap_y   <= pix_y;
            end
        end
    end

    assign in_range  = (cap_x < SRC_LIM) && (cap_y < SRC_LIM);
    assign is_origin = (cap_x == 10'd0) && (cap_y == 10'd0);
    assign is_last   = (cap_x == SRC_LAST) && (cap_y == SRC_LAST);
    assign aligned   = ((cap_x % POOL_W) == 10'd0) && ((cap_y % POOL_W) == 10'd0);
    assign cell_idx  = (cap_y / POOL_W) * DST_W + (cap_x / POOL_W);

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) state <= UNSYNC;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        if (cap_vld && in_range) begin
            if (state == UNSYNC) begin
                if (is_origin) begin
                    state_next = CAPTURE;
                    accept     = 1'b1;
                end
            end else begin
                accept = 1'b1;
            end
        end
    end

    assign fsm_state = state;

    // Aligned sample opens the cell, so stale bank contents never need clearing.
    assign val_ext = CELL_W'(b_val);
    always_comb begin
        new_cell = val_ext;
`ifdef RASTER_CAPTURE_COUNT_EN
        if (!b_aligned) new_cell = b_old + val_ext;
`else
        if (!b_aligned) new_cell = b_old | val_ext;
`endif
    end

    always_ff @(posedge clk_100M) begin
        if (accept) begin
            b_idx     <= cell_idx;
            b_val     <= cap_val;
            b_aligned <= aligned;
            b_last    <= is_last;
            b_old     <= bank_mem[w_bank][cell_idx];
        end
        if (b_vld) bank_mem[w_bank][b_idx] <= new_cell;
    end

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            b_vld  <= 1'b0;
            c_last <= 1'b0;
        end else begin
            b_vld  <= accept;
            c_last <= b_vld & b_last;
        end
    end

    // Handshake: frame_valid stays high until a cycle with frame_ack=1 while it is high;
    // the read bank is stable for that whole window. An ack in the frame-end cycle is
    // applied before the swap decision.
    assign fv_held = frame_valid & ~frame_ack;
    assign r_bank  = ~w_bank;

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
            frame_count <= 8'd0;
            overrun     <= 1'b0;
            w_bank      <= 1'b0;
        end else begin
            frame_valid <= fv_held | c_last;
            if (c_last) begin
                if (fv_held) begin
                    overrun <= 1'b1;
                end else begin
                    w_bank      <= ~w_bank;
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset)                 rd_data <= '0;
        else if (rd_addr < NCELL_W) rd_data <= bank_mem[r_bank][rd_addr];
        else                       rd_data <= '0;
    end

endmodule
